reg24_hold_ctrl: RTL and testbench
==================================

Name: reg24_hold_ctrl

Overview:
- 2-entry skid stage for signed N-bit data words. It is the producer of the hold (s) signal consumed by the hold-capable 24-bit pipeline registers.
- Accepts words from an upstream register chain and presents them downstream with a valid/ready handshake.
- Drives hold_out so upstream registers freeze whenever downstream back-pressure fills the stage.
- Counts back-pressure cycles for NPU performance debug.

Parameters:
N, 24, data width in bits (signed two's complement)
CW, 16, width of saturating hold-cycle counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous clear of buffered data (active high)
in_valid  input  1  upstream word present on in_data
in_data  input  N  signed upstream word
hold_out  output  1  hold to upstream registers; 1 = freeze, word not accepted this cycle
out_valid  output  1  out_data holds a valid word
out_data  output  N  signed word to downstream
out_ready  input  1  downstream can take out_data this cycle
occupancy  output  2  words buffered (0..2)
hold_cnt  output  CW  number of cycles with hold_out=1, saturating

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values (rst_n=0 at an edge):
  - state=EMPTY; main and skid registers = 0.
  - out_data=0, out_valid=0, hold_out=0, occupancy=0, hold_cnt=0.
  - Reset has priority over every other input. Asserting it mid-transfer discards both buffered words.
- Definitions:
  - accept = in_valid & ~hold_out
  - fire = out_valid & out_ready
- State machine (state register; out_valid, hold_out and occupancy decode from it, all registered):
  - EMPTY (occ 0): accept -> ONE, main<=in_data. Otherwise stay.
  - ONE (occ 1):
    - accept & fire -> ONE, main<=in_data.
    - fire only -> EMPTY.
    - accept only -> FULL, skid<=in_data.
    - neither -> ONE, main unchanged.
  - FULL (occ 2): hold_out=1, so accept is impossible. fire -> ONE, main<=skid. Otherwise stay, both words unchanged.
- Outputs by state:
  - out_valid=1 in ONE and FULL.
  - out_data = main register at all times. It keeps its last value in EMPTY and is 0 after reset.
  - hold_out=1 only in FULL. It is a registered state decode, with no combinational path from out_ready.
- Latency and throughput:
  - A word accepted at edge k appears on out_data after edge k (1-cycle latency).
  - With out_ready held 1, throughput is 1 word/cycle and the stage never reaches FULL.
- Ordering: words leave strictly in acceptance order. No loss, no duplication.
- Data width: in_data passes through unmodified as a signed N-bit value, with no extension or truncation. Full-range values (-2^(N-1) .. 2^(N-1)-1) pass bit-exact.
- Upstream contract: while hold_out=1, upstream keeps in_data/in_valid frozen (the hold-register behaviour). This block ignores in_valid while in FULL.
- flush (when rst_n=1):
  - Next state EMPTY, occupancy 0, out_valid 0, hold_out 0.
  - main and skid keep their contents but are invalid. hold_cnt is not cleared.
  - flush overrides a simultaneous accept or fire: the word is dropped and the fire is not counted.
- hold_cnt: increments by 1 on each edge where hold_out=1 (and rst_n=1). It saturates at 2^CW-1 and never wraps.
- in_valid=1 while in FULL is legal; no error is flagged.

Test Plan:
1. Reset, then stream 1280, 1456, 1143, 3527 with out_ready=1:
   - out_data shows each word one cycle after it is presented.
   - hold_out stays 0, occupancy never exceeds 1, hold_cnt=0.
2. out_ready=0, present 6668 then 7230:
   - After 2 edges, occupancy=2 and hold_out=1.
   - Present 8975 with in_valid=1 for 3 cycles: it is not accepted and hold_cnt=3.
   - Raise out_ready: output order is 6668, 7230, 8975.
3. In FULL (1183 in main, 1783 in skid), assert rst_n=0 for 1 edge:
   - All outputs 0.
   - After release, the next accepted word 1328 appears on out_data with out_valid=1.
4. In state ONE with 4343 present, assert flush together with in_valid=1, in_data=1427:
   - Next cycle out_valid=0, occupancy=0, 1427 dropped.
   - Following accepted word 3268 is output normally.
5. Boundary data: stream -8388608, 8388607, -1, 0 under random out_ready:
   - All four are output bit-exact and in order.
6. Set CW=4, hold out_ready=0 with the stage FULL for 20 cycles:
   - hold_cnt reaches 15 and holds at 15.
   - Data is intact when out_ready is raised.

Source files
------------

// File: rtl/reg24_hold_ctrl.sv
// ---------------------------------------------------------------------------
// reg24_hold_ctrl
//
// Two-entry skid stage for signed N-bit data words. It sits between a chain
// of hold-capable pipeline registers (upstream) and a valid/ready consumer
// (downstream). When downstream back-pressure fills both entries, hold_out
// freezes the upstream registers. A saturating counter records how many
// cycles the stage spent holding, for performance debug.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous clear of buffered words (active high)
//   in_valid   upstream word present on in_data
//   in_data    signed upstream word (N bits)
//   hold_out   1 = freeze upstream, word not accepted this cycle
//   out_valid  out_data holds a valid word
//   out_data   signed word to downstream (N bits)
//   out_ready  downstream can take out_data this cycle
//   occupancy  number of buffered words (0..2)
//   hold_cnt   saturating count of cycles with hold_out=1 (CW bits)
// ---------------------------------------------------------------------------
module reg24_hold_ctrl #(
    parameter int N  = 24,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    input  logic signed [N-1:0] in_data,
    output logic                hold_out,
    output logic                out_valid,
    output logic signed [N-1:0] out_data,
    input  logic                out_ready,
    output logic [1:0]          occupancy,
    output logic [CW-1:0]       hold_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [N-1:0]  main_q, main_d;
    logic signed [N-1:0]  skid_q, skid_d;
    logic [CW-1:0]        hold_cnt_q, hold_cnt_d;
    logic                 accept;
    logic                 fire;

    // Every output is a pure decode of registered state, so hold_out has no
    // combinational path from out_ready and upstream sees a clean freeze.
    // out_data is always the main register, which keeps its last contents
    // while the stage is empty.
    always_comb begin
        out_valid = 1'b0;
        hold_out  = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                hold_out  = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                hold_out  = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    assign out_data = main_q;
    assign hold_cnt = hold_cnt_q;

    // Handshake qualifiers. In FULL hold_out is high, so any in_valid seen
    // there is the frozen upstream word and is deliberately ignored.
    assign accept = in_valid & ~hold_out;
    assign fire   = out_valid & out_ready;

    // Next-state and datapath selection. The main register always holds the
    // oldest word; the skid register only fills when a word arrives while
    // the main word is stalled. Flush empties the stage but leaves the data
    // registers untouched, dropping any simultaneous accept or fire.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Hold-cycle counter: counts every edge spent in FULL, independent of
    // flush, and sticks at all-ones instead of wrapping so a long stall is
    // never misreported as a short one.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (hold_out && (hold_cnt_q != {CW{1'b1}})) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
    end

    // State and data registers with synchronous active-low reset, which
    // takes priority over everything and discards both buffered words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg24_hold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg24_hold_ctrl
//
// Directed bench for reg24_hold_ctrl. Two instances share the same stimulus:
// the default CW=16 stage and a CW=4 stage used to observe counter
// saturation. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_reg24_hold_ctrl;

    localparam int N = 24;

    logic                clk;
    logic                rstN;
    logic                flush;
    logic                inValid;
    logic signed [N-1:0] inData;
    logic                outReady;

    logic                holdOut;
    logic                outValid;
    logic signed [N-1:0] outData;
    logic [1:0]          occupancy;
    logic [15:0]         holdCnt;

    logic                holdOut4;
    logic                outValid4;
    logic signed [N-1:0] outData4;
    logic [1:0]          occupancy4;
    logic [3:0]          holdCnt4;

    int compared   = 0;
    int mismatched = 0;

    reg24_hold_ctrl #(.N(N), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .flush     (flush),
        .in_valid  (inValid),
        .in_data   (inData),
        .hold_out  (holdOut),
        .out_valid (outValid),
        .out_data  (outData),
        .out_ready (outReady),
        .occupancy (occupancy),
        .hold_cnt  (holdCnt)
    );

    reg24_hold_ctrl #(.N(N), .CW(4)) dut4 (
        .clk       (clk),
        .rst_n     (rstN),
        .flush     (flush),
        .in_valid  (inValid),
        .in_data   (inData),
        .hold_out  (holdOut4),
        .out_valid (outValid4),
        .out_data  (outData4),
        .out_ready (outReady),
        .occupancy (occupancy4),
        .hold_cnt  (holdCnt4)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all stimulus inputs at once, between clock edges.
    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic signed [N-1:0] d, input logic rdy);
        rstN     = r;
        flush    = f;
        inValid  = v;
        inData   = d;
        outReady = rdy;
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One counted comparison of an observed value against a bench constant.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    logic signed [N-1:0] streamWords [4];
    logic signed [N-1:0] boundWords [4];
    int inIdx;
    int outIdx;
    int cycles;

    initial begin
        streamWords[0] = 24'sd1280;
        streamWords[1] = 24'sd1456;
        streamWords[2] = 24'sd1143;
        streamWords[3] = 24'sd3527;
        boundWords[0]  = -24'sd8388608;
        boundWords[1]  = 24'sd8388607;
        boundWords[2]  = -24'sd1;
        boundWords[3]  = 24'sd0;

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("rstOutData", 32'(outData), 32'd0);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstHold", 32'(holdOut), 32'd0);
        checkOutput("rstOcc", 32'(occupancy), 32'd0);
        checkOutput("rstHoldCnt", 32'(holdCnt), 32'd0);

        // 1: streaming with out_ready=1
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, streamWords[i], 1'b1);
            tick();
            checkOutput("streamData", 32'(outData), 32'(streamWords[i]));
            checkOutput("streamValid", 32'(outValid), 32'd1);
            checkOutput("streamOcc", 32'(occupancy), 32'd1);
            checkOutput("streamHold", 32'(holdOut), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        checkOutput("streamDrainOcc", 32'(occupancy), 32'd0);
        checkOutput("streamDrainValid", 32'(outValid), 32'd0);
        checkOutput("streamKeepData", 32'(outData), 32'd3527);
        checkOutput("streamHoldCnt", 32'(holdCnt), 32'd0);

        // 2: back-pressure fills the stage
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd6668, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd7230, 1'b0);
        tick();
        checkOutput("fullOcc", 32'(occupancy), 32'd2);
        checkOutput("fullHold", 32'(holdOut), 32'd1);
        checkOutput("fullHoldCnt0", 32'(holdCnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd8975, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("fullHoldCnt3", 32'(holdCnt), 32'd3);
        checkOutput("fullStillOcc", 32'(occupancy), 32'd2);
        checkOutput("fullOrder0", 32'(outData), 32'd6668);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd8975, 1'b1);
        tick();
        checkOutput("fullOrder1", 32'(outData), 32'd7230);
        checkOutput("fullAfterOcc", 32'(occupancy), 32'd1);
        checkOutput("fullAfterHold", 32'(holdOut), 32'd0);
        tick();
        checkOutput("fullOrder2", 32'(outData), 32'd8975);
        checkOutput("fullOrder2Valid", 32'(outValid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        checkOutput("fullDrainOcc", 32'(occupancy), 32'd0);
        checkOutput("fullHoldCnt4", 32'(holdCnt), 32'd4);

        // 3: reset while FULL
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd1183, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd1783, 1'b0);
        tick();
        checkOutput("preRstOcc", 32'(occupancy), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("midRstData", 32'(outData), 32'd0);
        checkOutput("midRstValid", 32'(outValid), 32'd0);
        checkOutput("midRstHold", 32'(holdOut), 32'd0);
        checkOutput("midRstOcc", 32'(occupancy), 32'd0);
        checkOutput("midRstHoldCnt", 32'(holdCnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd1328, 1'b0);
        tick();
        checkOutput("postRstData", 32'(outData), 32'd1328);
        checkOutput("postRstValid", 32'(outValid), 32'd1);

        // 4: flush in ONE drops the simultaneous word
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd4343, 1'b1);
        tick();
        checkOutput("preFlushData", 32'(outData), 32'd4343);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'sd1427, 1'b0);
        tick();
        checkOutput("flushValid", 32'(outValid), 32'd0);
        checkOutput("flushOcc", 32'(occupancy), 32'd0);
        checkOutput("flushDropped", 32'(outData), 32'd4343);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd3268, 1'b0);
        tick();
        checkOutput("postFlushData", 32'(outData), 32'd3268);
        checkOutput("postFlushOcc", 32'(occupancy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        checkOutput("postFlushDrain", 32'(occupancy), 32'd0);

        // 5: full-range words under random out_ready
        inIdx  = 0;
        outIdx = 0;
        cycles = 0;
        while (outIdx < 4 && cycles < 200) begin
            applyStimulus(1'b1, 1'b0, (inIdx < 4) ? 1'b1 : 1'b0,
                          (inIdx < 4) ? boundWords[inIdx] : '0,
                          1'($urandom_range(0, 1)));
            #1;
            if (outValid && outReady) begin
                checkOutput("boundData", 32'(outData), 32'(boundWords[outIdx]));
                outIdx++;
            end
            if (inValid && !holdOut) begin
                inIdx++;
            end
            tick();
            cycles++;
        end
        checkOutput("boundCount", 32'(outIdx), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        tick();
        checkOutput("boundDrained", 32'(occupancy), 32'd0);

        // 6: counter saturation on the CW=4 instance
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd5000, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd6000, 1'b0);
        tick();
        checkOutput("satFullOcc", 32'(occupancy4), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd7000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        checkOutput("satReach", 32'(holdCnt4), 32'd15);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("satHeld", 32'(holdCnt4), 32'd15);
        checkOutput("wideCnt20", 32'(holdCnt), 32'd20);
        checkOutput("satData0", 32'(outData4), 32'd5000);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'sd7000, 1'b1);
        tick();
        checkOutput("satData1", 32'(outData4), 32'd6000);
        tick();
        checkOutput("satData2", 32'(outData4), 32'd7000);
        checkOutput("satAfter", 32'(holdCnt4), 32'd15);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        checkOutput("satDrained", 32'(occupancy4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
